// File: rtl/div_unit.sv
// div_unit: multicycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in EXE.
// Ports: clk/rst (sync, active-high); start/op/opA/opB request; flush abort;
//        div_running stall request; done one-cycle pulse with result (held until next accepted op).
// Latency: 35 cycles normal (accept, 32 x CALC, FIX, DONE), 2 cycles for divide-by-zero / signed overflow.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             flush,
    output logic             div_running,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t state, state_nxt;

    logic [1:0]       op_q;
    logic [WIDTH-1:0] quo;      // holds |A| on entry, shifts out dividend bits / in quotient bits
    logic [WIDTH-1:0] rem;      // partial remainder; always < B, so WIDTH bits suffice between steps
    logic [WIDTH-1:0] b_q;
    logic             q_neg;
    logic             r_neg;
    logic [CW-1:0]    cnt;

    // Request decode (op[0]=1 unsigned, op[1]=1 remainder)
    logic             is_signed;
    logic             div_zero;
    logic             ovf;
    logic             special;
    logic             accept;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;

    assign is_signed = ~op[0];
    assign div_zero  = (opB == '0);
    assign ovf       = is_signed && (opA == MIN_NEG) && (opB == '1);
    assign special   = div_zero || ovf;
    assign accept    = (state == IDLE) && start && !flush;
    assign a_abs     = (is_signed && opA[WIDTH-1]) ? (~opA + 1'b1) : opA;
    assign b_abs     = (is_signed && opB[WIDTH-1]) ? (~opB + 1'b1) : opB;

    // One restoring step: shift {rem, quo} left, try subtracting B in WIDTH+1 bits.
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic             trial_ok;

    assign rem_sh   = {rem, quo[WIDTH-1]};
    assign trial    = rem_sh - {1'b0, b_q};
    assign trial_ok = ~trial[WIDTH];

    // Sign fix-up applied in FIX
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign q_fix = (q_neg && op_q == 2'b00) ? (~quo + 1'b1) : quo;
    assign r_fix = (r_neg && op_q == 2'b10) ? (~rem + 1'b1) : rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        div_running = 1'b0;
        done        = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    div_running = 1'b1;
                    state_nxt   = special ? DONE : CALC;
                end
            end
            CALC: begin
                div_running = 1'b1;
                if (cnt == LAST_ITER) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                div_running = 1'b1;
                state_nxt   = DONE;
            end
            DONE: begin
                // start is still high from the departing instruction; it is not a new op
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= '0;
            quo    <= '0;
            rem    <= '0;
            b_q    <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            cnt    <= '0;
            result <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_q  <= op;
                        quo   <= a_abs;
                        b_q   <= b_abs;
                        q_neg <= opA[WIDTH-1] ^ opB[WIDTH-1];
                        r_neg <= opA[WIDTH-1];
                        rem   <= '0;
                        cnt   <= '0;
                        // Special cases skip CALC/FIX, so the answer is preset here
                        if (div_zero) begin
                            result <= op[1] ? opA : '1;
                        end else if (ovf) begin
                            result <= op[1] ? '0 : MIN_NEG;
                        end
                    end
                end
                CALC: begin
                    rem <= trial_ok ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], trial_ok};
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    // A flushed op must not overwrite the previous result
                    if (!flush) begin
                        result <= op_q[1] ? r_fix : q_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
